// File: rtl/aludec_pipe.sv
// Multi-lane MIPS ALU-control decoder with a single valid/ready output register,
// flush, reserved-instruction flags and a wrapping decoded-lane counter.
module aludec_pipe #(
   parameter int unsigned LANES   = 1,
   parameter bit          COP0_EN = 1'b1,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [32*LANES-1:0]  in_instr,
   input  logic [LANES-1:0]     in_lane_vld,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_alucontrol,
   output logic [LANES-1:0]     out_ri,
   output logic [LANES-1:0]     out_lane_vld,
   output logic [CNT_W-1:0]     dec_cnt
);

   localparam int unsigned IW = 32;
   localparam int unsigned AW = 8;

   localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;
   localparam logic [7:0] EXE_AND_OP    = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP     = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP    = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP    = 8'b0010_0111;
   localparam logic [7:0] EXE_ANDI_OP   = 8'b0101_1001;
   localparam logic [7:0] EXE_ORI_OP    = 8'b0101_1010;
   localparam logic [7:0] EXE_XORI_OP   = 8'b0101_1011;
   localparam logic [7:0] EXE_LUI_OP    = 8'b0101_1100;
   localparam logic [7:0] EXE_SLL_OP    = 8'b0111_1100;
   localparam logic [7:0] EXE_SLLV_OP   = 8'b0000_0100;
   localparam logic [7:0] EXE_SRL_OP    = 8'b0000_0010;
   localparam logic [7:0] EXE_SRLV_OP   = 8'b0000_0110;
   localparam logic [7:0] EXE_SRA_OP    = 8'b0000_0011;
   localparam logic [7:0] EXE_SRAV_OP   = 8'b0000_0111;
   localparam logic [7:0] EXE_MFHI_OP   = 8'b0001_0000;
   localparam logic [7:0] EXE_MTHI_OP   = 8'b0001_0001;
   localparam logic [7:0] EXE_MFLO_OP   = 8'b0001_0010;
   localparam logic [7:0] EXE_MTLO_OP   = 8'b0001_0011;
   localparam logic [7:0] EXE_SLT_OP    = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP   = 8'b0010_1011;
   localparam logic [7:0] EXE_SLTI_OP   = 8'b0101_0111;
   localparam logic [7:0] EXE_SLTIU_OP  = 8'b0101_1000;
   localparam logic [7:0] EXE_ADD_OP    = 8'b0010_0000;
   localparam logic [7:0] EXE_ADDU_OP   = 8'b0010_0001;
   localparam logic [7:0] EXE_SUB_OP    = 8'b0010_0010;
   localparam logic [7:0] EXE_SUBU_OP   = 8'b0010_0011;
   localparam logic [7:0] EXE_ADDI_OP   = 8'b0101_0101;
   localparam logic [7:0] EXE_ADDIU_OP  = 8'b0101_0110;
   localparam logic [7:0] EXE_MULT_OP   = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP  = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP    = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP   = 8'b0001_1011;
   localparam logic [7:0] EXE_J_OP      = 8'b0100_1111;
   localparam logic [7:0] EXE_JAL_OP    = 8'b0101_0000;
   localparam logic [7:0] EXE_JALR_OP   = 8'b0000_1001;
   localparam logic [7:0] EXE_BEQ_OP    = 8'b0101_0001;
   localparam logic [7:0] EXE_BGEZ_OP   = 8'b0100_0001;
   localparam logic [7:0] EXE_BGEZAL_OP = 8'b0100_1011;
   localparam logic [7:0] EXE_BGTZ_OP   = 8'b0101_0100;
   localparam logic [7:0] EXE_BLEZ_OP   = 8'b0101_0011;
   localparam logic [7:0] EXE_BLTZ_OP   = 8'b0100_0000;
   localparam logic [7:0] EXE_BLTZAL_OP = 8'b0100_1010;
   localparam logic [7:0] EXE_BNE_OP    = 8'b0101_0010;
   localparam logic [7:0] EXE_LB_OP     = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP    = 8'b1110_0100;
   localparam logic [7:0] EXE_LH_OP     = 8'b1110_0001;
   localparam logic [7:0] EXE_LHU_OP    = 8'b1110_0101;
   localparam logic [7:0] EXE_LW_OP     = 8'b1110_0011;
   localparam logic [7:0] EXE_SB_OP     = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP     = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP     = 8'b1110_1011;

   // Returns {ri, alucontrol} for one instruction.
   function automatic logic [AW:0] decode_lane(input logic [5:0] op,
                                               input logic [5:0] funct,
                                               input logic [4:0] rt);
      logic [AW-1:0] alu;
      logic          ri;
      alu = EXE_NOP_OP;
      ri  = 1'b0;
      case (op)
         6'b000000: begin
            case (funct)
               6'b100100: alu = EXE_AND_OP;
               6'b100101: alu = EXE_OR_OP;
               6'b100110: alu = EXE_XOR_OP;
               6'b100111: alu = EXE_NOR_OP;
               6'b000000: alu = EXE_SLL_OP;
               6'b000010: alu = EXE_SRL_OP;
               6'b000011: alu = EXE_SRA_OP;
               6'b000100: alu = EXE_SLLV_OP;
               6'b000110: alu = EXE_SRLV_OP;
               6'b000111: alu = EXE_SRAV_OP;
               6'b010000: alu = EXE_MFHI_OP;
               6'b010001: alu = EXE_MTHI_OP;
               6'b010010: alu = EXE_MFLO_OP;
               6'b010011: alu = EXE_MTLO_OP;
               6'b100000: alu = EXE_ADD_OP;
               6'b100001: alu = EXE_ADDU_OP;
               6'b100010: alu = EXE_SUB_OP;
               6'b100011: alu = EXE_SUBU_OP;
               6'b101010: alu = EXE_SLT_OP;
               6'b101011: alu = EXE_SLTU_OP;
               6'b011000: alu = EXE_MULT_OP;
               6'b011001: alu = EXE_MULTU_OP;
               6'b011010: alu = EXE_DIV_OP;
               6'b011011: alu = EXE_DIVU_OP;
               // jr shares the jump code; the EX stage distinguishes by register source
               6'b001000: alu = EXE_J_OP;
               6'b001001: alu = EXE_JALR_OP;
               default:   ri  = 1'b1;
            endcase
         end
         6'b000001: begin
            case (rt)
               5'b00001: alu = EXE_BGEZ_OP;
               5'b10001: alu = EXE_BGEZAL_OP;
               5'b00000: alu = EXE_BLTZ_OP;
               5'b10000: alu = EXE_BLTZAL_OP;
               default:  ri  = 1'b1;
            endcase
         end
         6'b001100: alu = EXE_ANDI_OP;
         6'b001110: alu = EXE_XORI_OP;
         6'b001111: alu = EXE_LUI_OP;
         6'b001101: alu = EXE_ORI_OP;
         6'b001000: alu = EXE_ADDI_OP;
         6'b001001: alu = EXE_ADDIU_OP;
         6'b001010: alu = EXE_SLTI_OP;
         6'b001011: alu = EXE_SLTIU_OP;
         6'b000100: alu = EXE_BEQ_OP;
         6'b000101: alu = EXE_BNE_OP;
         6'b000111: alu = EXE_BGTZ_OP;
         6'b000110: alu = EXE_BLEZ_OP;
         6'b000010: alu = EXE_J_OP;
         6'b000011: alu = EXE_JAL_OP;
         6'b100000: alu = EXE_LB_OP;
         6'b100100: alu = EXE_LBU_OP;
         6'b100001: alu = EXE_LH_OP;
         6'b100101: alu = EXE_LHU_OP;
         6'b100011: alu = EXE_LW_OP;
         6'b101000: alu = EXE_SB_OP;
         6'b101001: alu = EXE_SH_OP;
         6'b101011: alu = EXE_SW_OP;
         6'b111111: alu = 8'hFF;
         6'b010000: ri  = ~COP0_EN;
         default:   ri  = 1'b1;
      endcase
      return {ri, alu};
   endfunction

   logic                 valid_q, valid_d;
   logic [AW*LANES-1:0]  alu_q, alu_d;
   logic [LANES-1:0]     ri_q, ri_d;
   logic [LANES-1:0]     lvld_q, lvld_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [AW*LANES-1:0]  dec_alu_c;
   logic [LANES-1:0]     dec_ri_c;
   logic [CNT_W-1:0]     pop_c;
   logic                 accept_c;
   logic                 xfer_c;
   logic                 instr_unused_c;

   // Per-lane decode; invalid lanes are forced to a clean NOP with no ri flag.
   always_comb begin
      logic [AW:0] res;
      dec_alu_c      = '0;
      dec_ri_c       = '0;
      instr_unused_c = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         res = decode_lane(in_instr[IW*i+26 +: 6], in_instr[IW*i +: 6],
                           in_instr[IW*i+16 +: 5]);
         instr_unused_c = instr_unused_c ^ (^in_instr[IW*i+21 +: 5])
                                         ^ (^in_instr[IW*i+6 +: 10]);
         if (in_lane_vld[i]) begin
            dec_alu_c[AW*i +: AW] = res[AW-1:0];
            dec_ri_c[i]           = res[AW];
         end
      end
   end

   always_comb begin
      pop_c = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         pop_c = pop_c + CNT_W'(lvld_q[i]);
      end
   end

   assign in_ready = resetn & (~valid_q | out_ready);
   assign accept_c = in_valid & in_ready;
   assign xfer_c   = valid_q & out_ready;

   // Flush outranks both accept and transfer, and suppresses counting.
   always_comb begin
      valid_d = valid_q;
      alu_d   = alu_q;
      ri_d    = ri_q;
      lvld_d  = lvld_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
         alu_d   = '0;
         ri_d    = '0;
         lvld_d  = '0;
      end else begin
         if (xfer_c) begin
            cnt_d = cnt_q + pop_c;
         end
         if (accept_c) begin
            valid_d = 1'b1;
            alu_d   = dec_alu_c;
            ri_d    = dec_ri_c;
            lvld_d  = in_lane_vld;
         end else if (xfer_c) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         alu_q   <= '0;
         ri_q    <= '0;
         lvld_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         alu_q   <= alu_d;
         ri_q    <= ri_d;
         lvld_q  <= lvld_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_alucontrol = alu_q;
   assign out_ri         = ri_q;
   assign out_lane_vld   = lvld_q;
   assign dec_cnt        = cnt_q;

endmodule

// File: tb/tb_aludec_pipe.sv
// Directed bench for aludec_pipe: a 2-lane COP0-enabled 4-bit-counter instance
// and a 1-lane COP0-disabled instance, with hand-computed expected values.
module tb_aludec_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        resetn;

   // Instance A: LANES=2, COP0_EN=1, CNT_W=4
   logic        flush, in_valid, out_ready;
   logic [63:0] in_instr;
   logic [1:0]  in_lane_vld;
   logic        in_ready, out_valid;
   logic [15:0] out_alu;
   logic [1:0]  out_ri, out_lvld;
   logic [3:0]  dec_cnt;

   // Instance B: LANES=1, COP0_EN=0, CNT_W=32
   logic        flush_b, in_valid_b, out_ready_b;
   logic [31:0] in_instr_b;
   logic [0:0]  in_lane_vld_b;
   logic        in_ready_b, out_valid_b;
   logic [7:0]  out_alu_b;
   logic [0:0]  out_ri_b, out_lvld_b;
   logic [31:0] dec_cnt_b;

   aludec_pipe #(.LANES(2), .COP0_EN(1'b1), .CNT_W(4)) u_a (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_lane_vld(in_lane_vld),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alucontrol(out_alu), .out_ri(out_ri),
      .out_lane_vld(out_lvld), .dec_cnt(dec_cnt)
   );

   aludec_pipe #(.LANES(1), .COP0_EN(1'b0), .CNT_W(32)) u_b (
      .clk(clk), .resetn(resetn), .flush(flush_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_instr(in_instr_b), .in_lane_vld(in_lane_vld_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_alucontrol(out_alu_b), .out_ri(out_ri_b),
      .out_lane_vld(out_lvld_b), .dec_cnt(dec_cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [31:0] i1, input logic [31:0] i0,
                        input logic [1:0] lv, input logic rdy);
      in_valid    = v;
      in_instr    = {i1, i0};
      in_lane_vld = lv;
      out_ready   = rdy;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [15:0] alu,
                        input logic [1:0] ri, input logic [1:0] lv, input logic [3:0] cnt);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_alu"},   32'(out_alu),   32'(alu));
      chk({tag, "_ri"},    32'(out_ri),    32'(ri));
      chk({tag, "_lvld"},  32'(out_lvld),  32'(lv));
      chk({tag, "_cnt"},   32'(dec_cnt),   32'(cnt));
   endtask

   logic [31:0] bb_i0 [4];
   logic [31:0] bb_i1 [4];
   logic [1:0]  bb_lv [4];
   logic [15:0] bb_alu [4];
   logic [3:0]  bb_cnt [4];

   initial begin
      resetn = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
      in_instr_b = 32'h0; in_lane_vld_b = 1'b0;

      // Reset
      tick(); tick();
      chk_a("reset", 1'b0, 16'h0000, 2'b00, 2'b00, 4'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      resetn = 1'b1;
      #1 chk("idle_in_ready", 32'(in_ready), 32'd1);

      // addu / lui bundle, then transfer
      drive(1'b1, 32'h3C01ABCD, 32'h00221821, 2'b11, 1'b1);
      tick();
      chk_a("addu_lui", 1'b1, 16'h5C21, 2'b00, 2'b11, 4'd0);
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      tick();
      chk("addu_lui_drain_valid", 32'(out_valid), 32'd0);
      chk("addu_lui_cnt", 32'(dec_cnt), 32'd2);

      // Reserved encodings
      drive(1'b1, 32'h0000003F, 32'h48000000, 2'b11, 1'b1);
      tick();
      chk_a("rsv_op_funct", 1'b1, 16'h0000, 2'b11, 2'b11, 4'd2);
      drive(1'b1, 32'hFC000000, 32'h041F0000, 2'b11, 1'b1);
      tick();
      chk_a("regimm_ff", 1'b1, 16'hFF00, 2'b01, 2'b11, 4'd4);

      // Backpressure: hold for 3 cycles with a new bundle waiting
      drive(1'b1, 32'h8C000000, 32'h00000024, 2'b11, 1'b0);
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_a("bp_hold", 1'b1, 16'hFF00, 2'b01, 2'b11, 4'd4);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk_a("bp_swap", 1'b1, 16'hE324, 2'b00, 2'b11, 4'd6);

      // Four back-to-back bundles, one per cycle
      bb_i0[0] = 32'h00000000; bb_i1[0] = 32'h00000002; bb_lv[0] = 2'b11; bb_alu[0] = 16'h027C; bb_cnt[0] = 4'd8;
      bb_i0[1] = 32'h00000003; bb_i1[1] = 32'h00000004; bb_lv[1] = 2'b11; bb_alu[1] = 16'h0403; bb_cnt[1] = 4'd10;
      bb_i0[2] = 32'h0000001A; bb_i1[2] = 32'h00000008; bb_lv[2] = 2'b11; bb_alu[2] = 16'h4F1A; bb_cnt[2] = 4'd12;
      bb_i0[3] = 32'h00000009; bb_i1[3] = 32'h10000000; bb_lv[3] = 2'b01; bb_alu[3] = 16'h0009; bb_cnt[3] = 4'd14;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, bb_i1[k], bb_i0[k], bb_lv[k], 1'b1);
         tick();
         chk_a("b2b", 1'b1, bb_alu[k], 2'b00, bb_lv[k], bb_cnt[k]);
      end
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      tick();
      chk("b2b_drain_valid", 32'(out_valid), 32'd0);
      chk("b2b_drain_cnt", 32'(dec_cnt), 32'd15);

      // Flush beats accept and transfer
      drive(1'b1, 32'h24000000, 32'h20000000, 2'b11, 1'b0);
      tick();
      chk_a("pre_flush", 1'b1, 16'h5655, 2'b00, 2'b11, 4'd15);
      drive(1'b1, 32'h00000025, 32'h00000026, 2'b11, 1'b1);
      flush = 1'b1;
      #1 chk("flush_in_ready", 32'(in_ready), 32'd1);
      tick();
      flush = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_lvld", 32'(out_lvld), 32'd0);
      chk("flush_cnt", 32'(dec_cnt), 32'd15);

      // Counter wrap at 4 bits: 15 + 2 -> 1
      drive(1'b1, 32'h2C000000, 32'h28000000, 2'b11, 1'b1);
      tick();
      chk_a("wrap_load", 1'b1, 16'h5857, 2'b00, 2'b11, 4'd15);
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      tick();
      chk("wrap_cnt", 32'(dec_cnt), 32'd1);

      // mtc0 legal with COP0 enabled; invalid lane holding a reserved op stays clean
      drive(1'b1, 32'h48000000, 32'h40806000, 2'b01, 1'b1);
      tick();
      chk_a("cop0_en", 1'b1, 16'h0000, 2'b00, 2'b01, 4'd1);
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
      tick();
      chk("lane_vld_cnt", 32'(dec_cnt), 32'd2);

      // Reset in the middle of backpressure
      drive(1'b1, 32'h00000022, 32'h00000020, 2'b11, 1'b0);
      tick();
      chk_a("pre_reset", 1'b1, 16'h2220, 2'b00, 2'b11, 4'd2);
      resetn = 1'b0;
      #1 chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_a("mid_reset", 1'b0, 16'h0000, 2'b00, 2'b00, 4'd0);
      resetn = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

      // Single-lane instance with COP0 disabled
      in_valid_b = 1'b1; out_ready_b = 1'b1; in_lane_vld_b = 1'b1;
      in_instr_b = 32'h40806000;
      tick();
      chk("b_mtc0_valid", 32'(out_valid_b), 32'd1);
      chk("b_mtc0_alu", 32'(out_alu_b), 32'h00);
      chk("b_mtc0_ri", 32'(out_ri_b), 32'd1);
      in_instr_b = 32'hAC000000;
      tick();
      chk("b_sw_alu", 32'(out_alu_b), 32'hEB);
      chk("b_sw_ri", 32'(out_ri_b), 32'd0);
      chk("b_sw_cnt", dec_cnt_b, 32'd1);
      in_instr_b = 32'h04110000;
      tick();
      chk("b_bgezal_alu", 32'(out_alu_b), 32'h4B);
      chk("b_bgezal_cnt", dec_cnt_b, 32'd2);
      in_valid_b = 1'b0;
      tick();
      chk("b_drain_valid", 32'(out_valid_b), 32'd0);
      chk("b_drain_cnt", dec_cnt_b, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
